custom_rptr_rd_ctrl: RTL and testbench

Read-side controller of the asynchronous FIFO, in the read clock domain, directly downstream of the write-to-read pointer synchronizer. It consumes the twice-synchronized Gray write pointer and keeps the binary/Gray read pointer and the memory-side empty flag. It prefetches from the synchronous-read FIFO memory into a two-entry output buffer with a valid/ready interface. Its Gray read pointer feeds the read-to-write synchronizer.

---
 rtl/async_fifo_pkg.sv | 17 +
 rtl/custom_rd_outbuf.sv | 41 ++++
 rtl/custom_rptr_rd_ctrl.sv | 87 ++++++++
 tb/tb_custom_rptr_rd_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared pointer type and Gray/binary conversion helpers for the async FIFO
package async_fifo_pkg;
   localparam int ADDRSIZE = 4;

   typedef logic [ADDRSIZE:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return (b >> 1) ^ b;
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[ADDRSIZE] = g[ADDRSIZE];
      for (int i = ADDRSIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/custom_rd_outbuf.sv
// custom_rd_outbuf: two-entry output/skid buffer presenting memory read data as a valid/ready stream
module custom_rd_outbuf #(
   parameter int DATASIZE = 8
) (
   input  logic                rclk_i,
   input  logic                rrst_n_i,
   input  logic                i_push,
   input  logic [DATASIZE-1:0] i_push_data,
   input  logic                i_pop,
   output logic [1:0]          o_occ,
   output logic [DATASIZE-1:0] rdata_o,
   output logic                rvalid_o
);
   logic                r_out_valid;
   logic                r_skid_valid;
   logic [DATASIZE-1:0] r_out_data;
   logic [DATASIZE-1:0] r_skid_data;
   logic                w_to_out;

   // returned word lands in the output register when it is free or being vacated with no skid word waiting
   assign w_to_out = i_push && (!r_out_valid || (i_pop && !r_skid_valid));

   // output and skid registers; a pop with the skid full promotes the skid, keeping strict order
   always_ff @(posedge rclk_i or negedge rrst_n_i) begin
      if (!rrst_n_i) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_out_data   <= '0;
         r_skid_data  <= '0;
      end else begin
         r_out_valid  <= i_pop ? (r_skid_valid || i_push) : (r_out_valid || i_push);
         r_out_data   <= (i_pop && r_skid_valid) ? r_skid_data : (w_to_out ? i_push_data : r_out_data);
         r_skid_valid <= i_pop ? (r_skid_valid && i_push) : (r_skid_valid || (i_push && r_out_valid));
         r_skid_data  <= (i_push && !w_to_out) ? i_push_data : r_skid_data;
      end
   end

   assign o_occ    = {1'b0, r_out_valid} + {1'b0, r_skid_valid};
   assign rdata_o  = r_out_data;
   assign rvalid_o = r_out_valid;
endmodule

// File: rtl/custom_rptr_rd_ctrl.sv
// custom_rptr_rd_ctrl: async FIFO read-side pointer/empty control with prefetching output buffer (RD_LEVEL_EN adds level/almost-empty)
module custom_rptr_rd_ctrl #(
   parameter int ADDRSIZE      = 4,
   parameter int DATASIZE      = 8,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                rclk_i,
   input  logic                rrst_n_i,
   input  logic [ADDRSIZE:0]   wptr_sync2_rdclk,
   output logic [ADDRSIZE:0]   rptr_g,
   output logic [ADDRSIZE-1:0] raddr_o,
   output logic                ren_o,
   input  logic [DATASIZE-1:0] rdata_mem_i,
   output logic [DATASIZE-1:0] rdata_o,
   output logic                rvalid_o,
   input  logic                rready_i,
   output logic                rempty_o,
   output logic [ADDRSIZE:0]   rlevel_o,
   output logic                raempty_o
);
   import async_fifo_pkg::*;

   logic [ADDRSIZE:0] r_rbin;
   logic [ADDRSIZE:0] r_rgray;
   logic              r_rempty;
   logic              r_inflight;
   logic [ADDRSIZE:0] w_rbin_next;
   logic [ADDRSIZE:0] w_rgray_next;
   logic              w_pop;
   logic [1:0]        w_buf_occ;
   logic [2:0]        w_occ;

   assign w_pop        = rvalid_o && rready_i;
   assign w_occ        = {1'b0, w_buf_occ} + {2'b0, r_inflight};
   // prefetch only while a slot will be free once this cycle's pop completes
   assign ren_o        = !r_rempty && ((w_occ - {2'b0, w_pop}) < 3'd2);
   assign w_rbin_next  = r_rbin + {{ADDRSIZE{1'b0}}, ren_o};
   assign w_rgray_next = bin2gray(w_rbin_next);

   // read pointers, memory-side empty flag and the one-cycle in-flight marker
   always_ff @(posedge rclk_i or negedge rrst_n_i) begin
      if (!rrst_n_i) begin
         r_rbin     <= '0;
         r_rgray    <= '0;
         r_rempty   <= 1'b1;
         r_inflight <= 1'b0;
      end else begin
         r_rbin     <= w_rbin_next;
         r_rgray    <= w_rgray_next;
         r_rempty   <= (w_rgray_next == wptr_sync2_rdclk);
         r_inflight <= ren_o;
      end
   end

   assign rptr_g   = r_rgray;
   assign raddr_o  = r_rbin[ADDRSIZE-1:0];
   assign rempty_o = r_rempty;

   custom_rd_outbuf #(
      .DATASIZE(DATASIZE)
   ) u_outbuf (
      .rclk_i      (rclk_i),
      .rrst_n_i    (rrst_n_i),
      .i_push      (r_inflight),
      .i_push_data (rdata_mem_i),
      .i_pop       (w_pop),
      .o_occ       (w_buf_occ),
      .rdata_o     (rdata_o),
      .rvalid_o    (rvalid_o)
   );

`ifdef RD_LEVEL_EN
   logic [ADDRSIZE:0] r_level;

   // words visible to the consumer: unread memory words plus buffered and in-flight ones
   always_ff @(posedge rclk_i or negedge rrst_n_i) begin
      if (!rrst_n_i) r_level <= '0;
      else r_level <= gray2bin(wptr_sync2_rdclk) - r_rbin + {{(ADDRSIZE-2){1'b0}}, w_occ};
   end

   assign rlevel_o  = r_level;
   assign raempty_o = (r_level <= (ADDRSIZE+1)'(AEMPTY_THRESH));
`else
   assign rlevel_o  = '0;
   assign raempty_o = r_rempty;
`endif
endmodule

// File: tb/tb_custom_rptr_rd_ctrl.sv
// tb_custom_rptr_rd_ctrl: directed scoreboard bench for the async FIFO read-side controller
module tb_custom_rptr_rd_ctrl;
   logic       clk = 1'b0;
   logic       rrst_n;
   logic [4:0] wptr;
   logic [4:0] rptr_g;
   logic [3:0] raddr_o;
   logic       ren_o;
   logic [7:0] rdata_mem;
   logic [7:0] rdata_o;
   logic       rvalid_o;
   logic       rready;
   logic       rempty_o;
   logic [4:0] rlevel_o;
   logic       raempty_o;

   logic [7:0] mem [16];
   logic [7:0] q [$];
   logic [4:0] wcnt;
   int         rd_total;
   int         n_cmp = 0;
   int         n_err = 0;
   int         rd0;
   logic [7:0] held;
   logic [8:0] exp_d;

   always #5 clk = ~clk;

   custom_rptr_rd_ctrl dut (
      .rclk_i           (clk),
      .rrst_n_i         (rrst_n),
      .wptr_sync2_rdclk (wptr),
      .rptr_g           (rptr_g),
      .raddr_o          (raddr_o),
      .ren_o            (ren_o),
      .rdata_mem_i      (rdata_mem),
      .rdata_o          (rdata_o),
      .rvalid_o         (rvalid_o),
      .rready_i         (rready),
      .rempty_o         (rempty_o),
      .rlevel_o         (rlevel_o),
      .raempty_o        (raempty_o)
   );

   // synchronous-read memory model
   always @(posedge clk) if (ren_o) rdata_mem <= mem[raddr_o];

   // count issued reads since reset
   always @(posedge clk or negedge rrst_n)
      if (!rrst_n) rd_total <= 0;
      else if (ren_o) rd_total <= rd_total + 1;

   function automatic logic [4:0] gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [7:0] d);
      mem[wcnt[3:0]] = d;
      q.push_back(d);
      wcnt = wcnt + 5'd1;
      wptr = gray(wcnt);
   endtask

   task automatic tick();
      @(negedge clk);
      if (rrst_n && rvalid_o && rready) begin
         exp_d = (q.size() > 0) ? {1'b0, q.pop_front()} : 9'h100;
         chk("sb_data", {24'd0, rdata_o}, {23'd0, exp_d});
      end
      chk("rptr_track", {27'd0, rptr_g}, {27'd0, gray(rd_total[4:0])});
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int lim);
      for (int i = 0; i < lim && q.size() > 0; i++) tick();
      chk("drain_left", q.size(), 0);
   endtask

   initial begin
      rrst_n = 1'b0;
      rready = 1'b0;
      wcnt   = '0;
      wptr   = '0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      tick();
      tick();
      rrst_n = 1'b1;
      // idle with empty write pointer
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_ren", {31'd0, ren_o}, 0);
         chk("idle_empty", {31'd0, rempty_o}, 1);
      end
      chk("idle_valid", {31'd0, rvalid_o}, 0);
      chk("idle_rptr", {27'd0, rptr_g}, 0);
      chk("idle_rdata", {24'd0, rdata_o}, 0);
      chk("idle_level", {27'd0, rlevel_o}, 0);
      chk("idle_aempty", {31'd0, raempty_o}, 1);
      // three words, consumer always ready
      rready = 1'b1;
      push_word(8'hA1);
      push_word(8'hB2);
      push_word(8'hC3);
      tick();
      chk("t2_empty_fall", {31'd0, rempty_o}, 0);
      chk("t2_ren", {31'd0, ren_o}, 1);
      tick();
      chk("t2_valid_n2", {31'd0, rvalid_o}, 0);
      tick();
      chk("t2_valid_n3", {31'd0, rvalid_o}, 1);
      chk("t2_word_a", {24'd0, rdata_o}, 32'hA1);
      tick();
      chk("t2_word_b", {24'd0, rdata_o}, 32'hB2);
      tick();
      chk("t2_word_c", {24'd0, rdata_o}, 32'hC3);
      tick();
      chk("t2_valid_end", {31'd0, rvalid_o}, 0);
      chk("t2_rptr", {27'd0, rptr_g}, 32'h02);
      chk("t2_empty", {31'd0, rempty_o}, 1);
      // five words with consumer stalled: prefetch stops at two
      rready = 1'b0;
      rd0 = rd_total;
      for (int i = 0; i < 5; i++) push_word(8'h10 + 8'(i));
      for (int i = 0; i < 6; i++) tick();
      chk("t3_reads", rd_total - rd0, 2);
      chk("t3_valid", {31'd0, rvalid_o}, 1);
      chk("t3_head", {24'd0, rdata_o}, 32'h10);
`ifdef RD_LEVEL_EN
      chk("t3_level", {27'd0, rlevel_o}, 5);
`else
      chk("t3_level", {27'd0, rlevel_o}, 0);
`endif
      chk("t3_aempty", {31'd0, raempty_o}, 0);
      rready = 1'b1;
      drain(20);
      // one-cycle stall mid-stream
      for (int i = 0; i < 6; i++) push_word(8'h20 + 8'(i));
      for (int i = 0; i < 10 && !rvalid_o; i++) tick();
      chk("t4_valid", {31'd0, rvalid_o}, 1);
      tick();
      rready = 1'b0;
      held = rdata_o;
      tick();
      chk("t4_hold", {24'd0, rdata_o}, {24'd0, held});
      chk("t4_head", {24'd0, rdata_o}, {24'd0, q[0]});
      chk("t4_hold_valid", {31'd0, rvalid_o}, 1);
      rready = 1'b1;
      drain(20);
      // 40 streamed words across the pointer wrap
      for (int i = 0; i < 40; i++) begin
         push_word(8'h40 + 8'(i));
         tick();
      end
      drain(20);
      tick();
      tick();
      chk("t5_rptr", {27'd0, rptr_g}, 32'h1D);
      chk("t5_raddr", {28'd0, raddr_o}, 6);
      chk("t5_empty", {31'd0, rempty_o}, 1);
      // reset with words buffered and in flight
      rready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(8'h90 + 8'(i));
      tick();
      tick();
      rrst_n = 1'b0;
      #1;
      chk("t6_valid", {31'd0, rvalid_o}, 0);
      chk("t6_rdata", {24'd0, rdata_o}, 0);
      chk("t6_empty", {31'd0, rempty_o}, 1);
      chk("t6_ren", {31'd0, ren_o}, 0);
      chk("t6_rptr", {27'd0, rptr_g}, 0);
      chk("t6_raddr", {28'd0, raddr_o}, 0);
      chk("t6_level", {27'd0, rlevel_o}, 0);
      chk("t6_aempty", {31'd0, raempty_o}, 1);
      q.delete();
      wcnt = '0;
      wptr = '0;
      push_word(8'hD1);
      push_word(8'hE2);
      tick();
      rrst_n = 1'b1;
      tick();
      chk("t6_empty_fresh", {31'd0, rempty_o}, 0);
      chk("t6_ren_fresh", {31'd0, ren_o}, 1);
      rready = 1'b1;
      drain(20);
      tick();
      tick();
      chk("t6_rptr_end", {27'd0, rptr_g}, 32'h03);
      chk("t6_empty_end", {31'd0, rempty_o}, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
